alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//   Multi-cycle shift-add multiplier sequencer that borrows the shared 16-bit Hack ALU.
//   Does not contain an adder; drives the ALU operand and control pins, one ALU op per cycle.
//   The ALU is a combinational instance outside this block.
//   Sits beside the CPU datapath. The CPU starts a job and waits on done; a mux outside this
//   block gives this sequencer ALU ownership whenever busy=1.
// PARAMETERS
//   WIDTH       16  operand/result width; fixed to the ALU width, other values unsupported
//   EARLY_EXIT  1   1: stop after the highest set bit of the multiplier; 0: always 16 bit-steps
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous, active-high reset
//   start       in   1   request; accepted only when busy=0
//   op_a        in   16  multiplicand, sampled on accept
//   op_b        in   16  multiplier, sampled on accept
//   busy        out  1   job in progress (ADD/DBL states)
//   done        out  1   one-cycle pulse; result valid
//   result      out  16  product mod 2^16; held until next accept or reset
//   res_zr      out  1   result==0 (registered with result)
//   res_ng      out  1   result[15] (registered with result)
//   alu_x       out  16  ALU X operand
//   alu_y       out  16  ALU Y operand
//   alu_ctl     out  6   {zx,nx,zy,ny,f,no} to ALU
//   alu_out     in   16  ALU OUT, sampled in the same cycle (combinational loop-free)
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, res_zr=1, res_ng=0, internal regs=0.
//   Reset values of the ALU pins: alu_x=0, alu_y=0, alu_ctl=6'b101010 (constant 0).
//   ALU codes used: ADD=6'b000010 (x+y), PASSX=6'b001100 (x).
//   Outside ADD/DBL the ALU pins hold their reset values.
//   Internal regs: prod, mcand, mplier (16 b each), cnt (5 b).
//   States: IDLE, ADD, DBL, DONE.
//   IDLE/DONE, start=1:
//     - prod<=0, mcand<=op_a, mplier<=op_b, cnt<=0.
//     - next state = DONE if (op_b==0 && EARLY_EXIT) else ADD.
//   IDLE/DONE, start=0: DONE -> IDLE; IDLE stays.
//   done=1 only in the DONE state (exactly one cycle unless a restart hits DONE->DONE).
//   ADD:
//     - alu_x=prod, alu_y=mcand, alu_ctl = mplier[0] ? ADD : PASSX.
//     - prod<=alu_out; -> DBL.
//   DBL:
//     - alu_x=mcand, alu_y=mcand, alu_ctl=ADD (doubling = left shift).
//     - mcand<=alu_out, mplier<=mplier>>1, cnt<=cnt+1.
//     - -> DONE if cnt==15, or if (EARLY_EXIT && (mplier>>1)==0); else -> ADD.
//   On entry to DONE: result<=prod, res_zr<=(prod==0), res_ng<=prod[15].
//   Overflow: silently discarded (mod 2^16), no flag. Signed op_b behaves as 16-bit unsigned.
//   Latency from the accept edge T: done high in cycle T+2k+1.
//     - k = index of highest set bit of op_b, +1 (EARLY_EXIT=1); k=16 when EARLY_EXIT=0.
//     - op_b==0 with EARLY_EXIT=1: done at T+1.
//   start while busy=1: ignored, no queueing, no effect on the running job.
//   start in the DONE cycle: accepted (back-to-back jobs); done still pulses for the old result.
//   rst mid-job: abort immediately to the reset state; the partial product is discarded.
// TESTING
//   1. op_a=3, op_b=5, EARLY_EXIT=1 -> done at T+7 (k=3), result=15, zr=0, ng=0.
//   2. op_a=3, op_b=5, EARLY_EXIT=0 -> done at T+33, result=15; ALU pins idle code after.
//   3. 0xFFFF*0xFFFF -> done at T+33, result=0x0001. 0x0100*0x0100 -> result=0, zr=1.
//   4. 0x8000*1 -> done at T+3, result=0x8000, ng=1. op_b=0 -> done at T+1, result=0, zr=1.
//   5. Job 7*9, mid-job start with op_a=2/op_b=2 -> ignored, result=63.
//      Then restart in the DONE cycle -> next done gives 4.
//   6. rst at T+4 of 0x1234*0x00FF -> next cycle busy=0, result=0, alu_ctl=101010.
//      A new 6*7 job then yields 42.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer. It owns no adder and issues one operation per cycle
// to the shared 16-bit Hack ALU, which sits outside this block.
module alu_mul_seq #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             res_zr,
   output logic             res_ng,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_ctl,
   input  logic [WIDTH-1:0] alu_out
);

   // ALU control words, bit order {zx,nx,zy,ny,f,no}
   localparam logic [5:0] CTL_ADD   = 6'b000010;
   localparam logic [5:0] CTL_PASSX = 6'b001100;
   localparam logic [5:0] CTL_ZERO  = 6'b101010;
   localparam logic [4:0] LAST_CNT  = 5'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DBL,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [4:0]       cnt;

   logic accept;
   logic zero_job;
   logic last_step;

   assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
   // A zero multiplier needs no bit-steps when early exit is enabled.
   assign zero_job  = accept && EARLY_EXIT && (op_b == '0);
   assign last_step = (state == S_DBL) &&
                      ((cnt == LAST_CNT) || (EARLY_EXIT && (mplier[WIDTH-1:1] == '0)));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: default every always_comb output first so no path leaves one unassigned
   // and infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_nx = zero_job ? S_DONE : S_ADD;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_ADD: state_nx = S_DBL;
         S_DBL: state_nx = last_step ? S_DONE : S_ADD;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      alu_x   = '0;
      alu_y   = '0;
      alu_ctl = CTL_ZERO;
      case (state)
         S_ADD: begin
            busy    = 1'b1;
            alu_x   = prod;
            alu_y   = mcand;
            alu_ctl = mplier[0] ? CTL_ADD : CTL_PASSX;
         end
         S_DBL: begin
            busy    = 1'b1;
            alu_x   = mcand;
            alu_y   = mcand;
            alu_ctl = CTL_ADD;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the working registers are reset too, so an aborted job leaves no
   // partial product behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (accept) begin
         prod   <= '0;
         mcand  <= op_a;
         mplier <= op_b;
         cnt    <= '0;
      end else if (state == S_ADD) begin
         prod   <= alu_out;
      end else if (state == S_DBL) begin
         mcand  <= alu_out;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
      end
   end

   // Result flags are registered together with the product on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         res_zr <= 1'b1;
         res_ng <= 1'b0;
      end else if (zero_job) begin
         result <= '0;
         res_zr <= 1'b1;
         res_ng <= 1'b0;
      end else if (last_step) begin
         result <= prod;
         res_zr <= (prod == '0);
         res_ng <= prod[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: one early-exit and one fixed-length instance,
// each driving its own behavioural Hack ALU.
module tb_alu_mul_seq;

   localparam logic [5:0] CTL_IDLE  = 6'b101010;
   localparam logic [5:0] CTL_ADD   = 6'b000010;
   localparam logic [5:0] CTL_PASSX = 6'b001100;

   typedef struct {
      int          dut;
      logic [15:0] res;
      logic        zr;
      logic        ng;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start   [2];
   logic [15:0] op_a    [2];
   logic [15:0] op_b    [2];
   logic        busy    [2];
   logic        done    [2];
   logic [15:0] result  [2];
   logic        res_zr  [2];
   logic        res_ng  [2];
   logic [15:0] alu_x   [2];
   logic [15:0] alu_y   [2];
   logic [5:0]  alu_ctl [2];
   logic [15:0] alu_out [2];

   int   cyc = 0;
   int   free_cyc [2] = '{0, 0};
   int   acc_cyc  [2] = '{0, 0};
   exp_t sb [$];
   int   n_checks = 0;
   int   n_errors = 0;

   alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .op_a(op_a[0]), .op_b(op_b[0]),
      .busy(busy[0]), .done(done[0]), .result(result[0]), .res_zr(res_zr[0]),
      .res_ng(res_ng[0]), .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_ctl(alu_ctl[0]),
      .alu_out(alu_out[0])
   );

   alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .op_a(op_a[1]), .op_b(op_b[1]),
      .busy(busy[1]), .done(done[1]), .result(result[1]), .res_zr(res_zr[1]),
      .res_ng(res_ng[1]), .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_ctl(alu_ctl[1]),
      .alu_out(alu_out[1])
   );

   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] ctl);
      logic [15:0] xv;
      logic [15:0] yv;
      logic [15:0] o;
      xv = ctl[5] ? 16'h0000 : x;
      xv = ctl[4] ? ~xv : xv;
      yv = ctl[3] ? 16'h0000 : y;
      yv = ctl[2] ? ~yv : yv;
      o  = ctl[1] ? (xv + yv) : (xv & yv);
      return ctl[0] ? ~o : o;
   endfunction

   assign alu_out[0] = hack_alu(alu_x[0], alu_y[0], alu_ctl[0]);
   assign alu_out[1] = hack_alu(alu_x[1], alu_y[1], alu_ctl[1]);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycles from the accept edge to the done cycle.
   function automatic int latency(input int d, input logic [15:0] b);
      if (d == 1) return 33;
      for (int i = 15; i >= 0; i--) begin
         if (b[i]) return 2 * (i + 1) + 1;
      end
      return 1;
   endfunction

   // Called at a falling edge; start is held across one rising edge.
   task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] p;
      start[d] = 1'b1;
      op_a[d]  = a;
      op_b[d]  = b;
      if (cyc >= free_cyc[d]) begin
         p           = 32'(a) * 32'(b);
         e.dut       = d;
         e.res       = p[15:0];
         e.zr        = (p[15:0] == 16'h0000);
         e.ng        = p[15];
         e.cyc       = cyc + latency(d, b);
         acc_cyc[d]  = cyc;
         free_cyc[d] = e.cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      start[d] = 1'b0;
      op_a[d]  = 16'($urandom);
      op_b[d]  = 16'($urandom);
   endtask

   task automatic wait_until(input int target);
      int guard = 0;
      while (cyc < target && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("wait_until bound", 32'(cyc >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      for (int d = 0; d < 2; d++) begin
         free_cyc[d] = 0;
         acc_cyc[d]  = 0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("dut%0d reset result", d), 32'(result[d]), 32'h0);
         check($sformatf("dut%0d reset zr", d), 32'(res_zr[d]), 32'd1);
         check($sformatf("dut%0d reset ng", d), 32'(res_ng[d]), 32'd0);
         check($sformatf("dut%0d reset alu_ctl", d), 32'(alu_ctl[d]), 32'(CTL_IDLE));
      end
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: pops the oldest expectation of each instance when it raises done.
   int   mon_idx;
   logic mon_busy;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mon_idx = -1;
         for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == d) begin
               mon_idx = i;
               break;
            end
         end
         mon_busy = (cyc > acc_cyc[d]) && (cyc < free_cyc[d]);
         check($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(mon_busy));
         if (!mon_busy) begin
            check($sformatf("dut%0d idle alu_ctl", d), 32'(alu_ctl[d]), 32'(CTL_IDLE));
            check($sformatf("dut%0d idle alu_x", d), 32'(alu_x[d]), 32'h0);
            check($sformatf("dut%0d idle alu_y", d), 32'(alu_y[d]), 32'h0);
         end else begin
            check($sformatf("dut%0d busy alu_ctl legal", d),
                  32'(alu_ctl[d] == CTL_ADD || alu_ctl[d] == CTL_PASSX), 32'd1);
         end
         if (done[d]) begin
            if (mon_idx < 0) begin
               check($sformatf("dut%0d done unexpected", d), 32'(done[d]), 32'd0);
            end else begin
               check($sformatf("dut%0d done cycle", d), 32'(cyc), 32'(sb[mon_idx].cyc));
               check($sformatf("dut%0d result", d), 32'(result[d]), 32'(sb[mon_idx].res));
               check($sformatf("dut%0d res_zr", d), 32'(res_zr[d]), 32'(sb[mon_idx].zr));
               check($sformatf("dut%0d res_ng", d), 32'(res_ng[d]), 32'(sb[mon_idx].ng));
               sb.delete(mon_idx);
            end
         end else if (mon_idx >= 0 && cyc >= sb[mon_idx].cyc) begin
            check($sformatf("dut%0d done missing", d), 32'(done[d]), 32'd1);
            sb.delete(mon_idx);
         end
      end
   end

   initial begin
      int          d;
      logic [15:0] a;
      logic [15:0] b;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         op_a[i]  = '0;
         op_b[i]  = '0;
      end
      @(negedge clk);
      do_reset();

      // Directed cases
      issue(0, 16'd3, 16'd5);
      issue(1, 16'd3, 16'd5);
      wait_until(free_cyc[0] + 1);
      issue(0, 16'hFFFF, 16'hFFFF);
      wait_until(free_cyc[0] + 1);
      issue(0, 16'h0100, 16'h0100);
      wait_until(free_cyc[0] + 1);
      issue(0, 16'h8000, 16'h0001);
      wait_until(free_cyc[0] + 1);
      issue(0, 16'h1234, 16'h0000);
      wait_until(free_cyc[1] + 1);
      issue(1, 16'hFFFF, 16'hFFFF);
      wait_until(free_cyc[1] + 1);
      issue(1, 16'h1234, 16'h0000);
      wait_until(free_cyc[1] + 1);

      // Ignored mid-job start, then a restart in the DONE cycle
      issue(0, 16'd7, 16'd9);
      repeat (2) @(negedge clk);
      issue(0, 16'd2, 16'd2);
      wait_until(free_cyc[0]);
      issue(0, 16'd2, 16'd2);
      wait_until(free_cyc[0] + 1);

      // Abort mid-job, then a clean job
      issue(0, 16'h1234, 16'h00FF);
      repeat (2) @(negedge clk);
      do_reset();
      issue(0, 16'd6, 16'd7);
      wait_until(free_cyc[0] + 1);

      // Random jobs, some back-to-back in DONE, some with stray starts while busy
      for (int n = 0; n < 60; n++) begin
         d = int'($urandom_range(0, 1));
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       b = 16'($urandom) & 16'h000F;
            1:       b = 16'($urandom) & 16'h00FF;
            2:       b = 16'(1) << $urandom_range(0, 15);
            default: b = 16'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1) begin
            wait_until(free_cyc[d]);
         end else begin
            wait_until(free_cyc[d] + int'($urandom_range(1, 3)));
         end
         issue(d, a, b);
         if ($urandom_range(0, 3) == 0) begin
            issue(d, 16'($urandom), 16'($urandom));
         end
      end

      wait_until((free_cyc[0] > free_cyc[1] ? free_cyc[0] : free_cyc[1]) + 2);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
               n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
